// File: rtl/priority_arbiter.sv
// ---------------------------------------------------------------------------
// PriorityArbiter (module priority_arbiter)
//
// Purpose:
//   Grants one of N requesters at a time and holds that grant until the
//   holder signals done. The arbitration policy is either fixed priority,
//   where the highest asserted index wins, or round-robin, where the search
//   starts at a rotating pointer and wraps around. When done arrives, the
//   arbiter picks the next holder on the same edge, so back-to-back grants
//   have no idle gap. The releasing requester is excluded from that pick.
//
// Parameters:
//   N   number of requesters (2..32)
//   RR  0 = fixed priority (highest index wins), 1 = round-robin
//   IW  grant index width, defaults to $clog2(N)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   req        request vector, bit i belongs to requester i
//   done       current holder releases (only looked at while granting)
//   gnt        registered one-hot grant vector (zero when idle)
//   gnt_idx    registered binary index of the holder (zero when idle)
//   gnt_valid  high while a grant is held
//   gnt_count  16-bit saturating count of grants issued
//              (present only when PRIORITY_ARBITER_STATS_EN is defined)
//
// Build option:
//   PRIORITY_ARBITER_STATS_EN  adds the gnt_count output and its counter.
// ---------------------------------------------------------------------------
module priority_arbiter #(
   parameter int N  = 8,
   parameter int RR = 0,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          done,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_valid
`ifdef PRIORITY_ARBITER_STATS_EN
   ,
   output logic [15:0]   gnt_count
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] gntIdx_q, gntIdx_d;
   logic          gntValid_q, gntValid_d;
   logic [IW-1:0] ptr_q, ptr_d;

   logic          arbitrate;
   logic [N-1:0]  reqCand;
   logic          winFound;
   logic [IW-1:0] winIdx;

   // A new decision is taken either from IDLE or when the holder releases.
   // On release, the holder's own bit is masked off. This stops a requester
   // that keeps its req high from winning again straight away.
   always_comb begin
      arbitrate = (state_q == IDLE) || done;
      reqCand   = '0;
      if (state_q == IDLE) begin
         reqCand = req;
      end else if (done) begin
         reqCand = req & ~gnt_q;
      end
   end

   // Winner search over the candidate vector.
   // In fixed mode, the scan runs from low to high, so the last hit (the
   // highest index) wins.
   // In round-robin mode, the scan walks the distance from the pointer
   // downwards. This leaves the candidate closest to the pointer (going
   // upward with wrap) as the final winner.
   always_comb begin
      int j;
      winFound = 1'b0;
      winIdx   = '0;
      j        = 0;
      if (RR == 0) begin
         for (int i = 0; i < N; i++) begin
            if (reqCand[IW'(i)]) begin
               winFound = 1'b1;
               winIdx   = IW'(i);
            end
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
               j = j - N;
            end
            if (reqCand[IW'(j)]) begin
               winFound = 1'b1;
               winIdx   = IW'(j);
            end
         end
      end
   end

   // Next-state decode.
   // While a grant is held and done is low, everything stays put, whatever
   // happens on req. When a decision is due, either a winner is loaded or
   // the arbiter drops back to IDLE with all outputs cleared. The round-robin
   // pointer moves to the slot just after each new winner. It never moves in
   // fixed mode.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gntIdx_d   = gntIdx_q;
      gntValid_d = gntValid_q;
      ptr_d      = ptr_q;
      if (arbitrate) begin
         if (winFound) begin
            state_d         = GRANT;
            gnt_d           = '0;
            gnt_d[winIdx]   = 1'b1;
            gntIdx_d        = winIdx;
            gntValid_d      = 1'b1;
            if (RR != 0) begin
               ptr_d = (winIdx == IW'(N - 1)) ? '0 : winIdx + 1'b1;
            end
         end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            gntIdx_d   = '0;
            gntValid_d = 1'b0;
         end
      end
   end

   // State and output registers.
   // Reset is asynchronous, so a grant in progress disappears at once,
   // without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gntIdx_q   <= '0;
         gntValid_q <= 1'b0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gntIdx_q   <= gntIdx_d;
         gntValid_q <= gntValid_d;
         ptr_q      <= ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gntIdx_q;
   assign gnt_valid = gntValid_q;

`ifdef PRIORITY_ARBITER_STATS_EN
   // Grant statistics.
   // Every winner that gets loaded counts as one grant, including
   // back-to-back handovers. The counter sticks at all-ones instead of
   // wrapping.
   logic        newGrant;
   logic [15:0] gntCount_q;

   assign newGrant = arbitrate && winFound;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gntCount_q <= '0;
      end else if (newGrant && (gntCount_q != 16'hFFFF)) begin
         gntCount_q <= gntCount_q + 16'd1;
      end
   end

   assign gnt_count = gntCount_q;
`else
   // Statistics are not built in; no counter exists.
`endif

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of requesters (2..32).
REQ-002 SHALL have parameter RR, default 0, meaning 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 SHALL have parameter IW, default $clog2(N), meaning grant index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port req  input  N  request vector; bit i = requester i.
REQ-007 SHALL have port done  input  1  current grant holder releases; sampled only in GRANT.
REQ-008 SHALL have port gnt  output  N  registered one-hot grant vector.
REQ-009 SHALL have port gnt_idx  output  IW  registered binary index of the granted requester.
REQ-010 SHALL have port gnt_valid  output  1  high while a grant is held.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GRANT.
- IDLE: req != 0 -> GRANT, winner registered.
- IDLE: req == 0 -> stay.
REQ-012 SHALL present gnt/gnt_idx/gnt_valid one cycle after the edge sampling the winning req (latency 1 clock).
REQ-013 SHALL, in fixed mode, select the highest-index asserted req bit (req=4'b1100 -> idx 3).
REQ-014 SHALL, in RR mode, search from pointer p upward with wrap-around (p, p+1, ..., N-1, 0, ...).
REQ-015 SHALL, in RR mode, load p = (idx+1) mod N on every new grant; N-1 wraps to 0.
REQ-016 SHALL hold gnt/gnt_idx stable during GRANT until done=1, even if the holder drops its req or other reqs change.
REQ-017 SHALL, in GRANT with done=1:
- re-arbitrate in the same edge over current req, excluding the releasing requester's bit;
- if a winner exists, issue it on the next cycle (back-to-back, no IDLE bubble);
- otherwise go to IDLE.
REQ-018 SHALL ignore done while in IDLE.
REQ-019 SHALL keep gnt one-hot or zero at all times; gnt_valid = |gnt; gnt_idx = 0 when gnt_valid=0.
REQ-020 SHALL, in fixed mode, leave p unused and constant 0.

Reset
REQ-021 SHALL, on rst=1, immediately (without a clock) force state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, p=0, grant counter=0.
REQ-022 SHALL drop any grant in progress on reset asserted mid-GRANT.
REQ-023 SHALL arbitrate normally on the first rising clk edge after rst deasserts.

Configuration
REQ-024 SHALL, when macro PRIORITY_ARBITER_STATS_EN is defined, add output gnt_count (16 bits).
- Increments by 1 on every new grant, including back-to-back grants.
- Saturates at 16'hFFFF.
REQ-025 SHALL, when PRIORITY_ARBITER_STATS_EN is undefined, omit gnt_count and its logic entirely; all other behaviour is identical.

Verification (N=4)
REQ-026 SHALL cover: RR=0, req=4'b0001 -> next cycle gnt=4'b0001, idx=0, valid=1; done -> gnt=0, valid=0.
REQ-027 SHALL cover: RR=0, req=4'b1100 -> gnt=4'b1000, idx=3; req changed to 4'b0100 without done -> gnt stays 4'b1000.
REQ-028 SHALL cover: RR=1, req=4'b1111 held, done pulsed each grant -> idx sequence 0,1,2,3,0 with no IDLE cycles between grants.
REQ-029 SHALL cover: RR=1, p=3 after granting 2, req=4'b0101 -> idx=0 (wrap-around), then p=1.
REQ-030 SHALL cover: rst asserted mid-GRANT between clock edges -> gnt=0, valid=0 immediately; after release with req=4'b0010 -> idx=1.
REQ-031 SHALL cover, with STATS_EN: 5 grants -> gnt_count=5; counter preloaded at 16'hFFFF plus one more grant -> remains 16'hFFFF.
